// File: rtl/any1_bus_arbiter.sv
// Two-master round-robin arbiter for a shared 128-bit Wishbone-style slave bus.
// The granted master owns the bus until it drops cyc; stalled slaves get a bus error after a timeout.
module any1_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         m0_cyc_i,
  input  logic         m0_stb_i,
  input  logic         m0_we_i,
  input  logic [15:0]  m0_sel_i,
  input  logic [31:0]  m0_adr_i,
  input  logic [127:0] m0_dat_i,
  input  logic [2:0]   m0_cti_i,
  input  logic [1:0]   m0_bte_i,
  input  logic         m1_cyc_i,
  input  logic         m1_stb_i,
  input  logic         m1_we_i,
  input  logic [15:0]  m1_sel_i,
  input  logic [31:0]  m1_adr_i,
  input  logic [127:0] m1_dat_i,
  input  logic [2:0]   m1_cti_i,
  input  logic [1:0]   m1_bte_i,
  output logic         m0_ack_o,
  output logic         m0_err_o,
  output logic         m1_ack_o,
  output logic         m1_err_o,
  output logic [127:0] m_dat_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [15:0]  s_sel_o,
  output logic [31:0]  s_adr_o,
  output logic [127:0] s_dat_o,
  output logic [2:0]   s_cti_o,
  output logic [1:0]   s_bte_o,
  input  logic         s_ack_i,
  input  logic         s_err_i,
  input  logic [127:0] s_dat_i,
  output logic [1:0]   owner_o
);

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  owner;
  logic        last_owner;   // 1 = m1 was the previous owner
  logic [15:0] tmo_cnt;
  logic        busy;
  logic        own_cyc;
  logic        tmo_hit;

  assign busy    = (state == BUSY);
  assign own_cyc = owner[1] ? m1_cyc_i : m0_cyc_i;
  assign tmo_hit = busy && s_stb_o && !s_ack_i && !s_err_i && (tmo_cnt == TMO_LAST);
  assign owner_o = owner;
  assign m_dat_o = s_dat_i;

  // Slave bus mux: only the owner drives the slave, and only while BUSY
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (busy) begin
      if (owner[1]) begin
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end else begin
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
    end
  end

  // Error wins over a simultaneous ack
  assign m0_ack_o = busy && (owner == 2'b01) && s_ack_i && !s_err_i;
  assign m1_ack_o = busy && (owner == 2'b10) && s_ack_i && !s_err_i;
  assign m0_err_o = busy && (owner == 2'b01) && (s_err_i || tmo_hit);
  assign m1_err_o = busy && (owner == 2'b10) && (s_err_i || tmo_hit);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      owner      <= 2'b00;
      last_owner <= 1'b1;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            owner <= last_owner ? 2'b01 : 2'b10;
            state <= BUSY;
          end else if (m0_cyc_i) begin
            owner <= 2'b01;
            state <= BUSY;
          end else if (m1_cyc_i) begin
            owner <= 2'b10;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!own_cyc) begin
            state      <= IDLE;
            owner      <= 2'b00;
            last_owner <= owner[1];
            tmo_cnt    <= '0;
          end else begin
            if (tmo_hit)
              state <= ABORT;
            if (s_ack_i || s_err_i)
              tmo_cnt <= '0;
            else if (s_stb_o)
              tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            state      <= IDLE;
            owner      <= 2'b00;
            last_owner <= owner[1];
            tmo_cnt    <= '0;
          end
        end
        default: begin
          state <= IDLE;
          owner <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_any1_bus_arbiter.sv
// Directed bench for any1_bus_arbiter: round robin, burst hold, timeout/abort,
// ack+err collision and mid-transfer reset.
module tb_any1_bus_arbiter;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         m0_cyc_i, m0_stb_i, m0_we_i;
  logic [15:0]  m0_sel_i;
  logic [31:0]  m0_adr_i;
  logic [127:0] m0_dat_i;
  logic [2:0]   m0_cti_i;
  logic [1:0]   m0_bte_i;
  logic         m1_cyc_i, m1_stb_i, m1_we_i;
  logic [15:0]  m1_sel_i;
  logic [31:0]  m1_adr_i;
  logic [127:0] m1_dat_i;
  logic [2:0]   m1_cti_i;
  logic [1:0]   m1_bte_i;
  logic         m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [127:0] m_dat_o;
  logic         s_cyc_o, s_stb_o, s_we_o;
  logic [15:0]  s_sel_o;
  logic [31:0]  s_adr_o;
  logic [127:0] s_dat_o;
  logic [2:0]   s_cti_o;
  logic [1:0]   s_bte_o;
  logic         s_ack_i, s_err_i;
  logic [127:0] s_dat_i;
  logic [1:0]   owner_o;

  int n_chk  = 0;
  int n_fail = 0;

  any1_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m_dat_o(m_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i),
    .owner_o(owner_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = '0; m0_adr_i = '0;
    m0_dat_i = '0;   m0_cti_i = '0;   m0_bte_i = '0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = '0; m1_adr_i = '0;
    m1_dat_i = '0;   m1_cti_i = '0;   m1_bte_i = '0;
    s_ack_i = 1'b1; s_err_i = 1'b0; s_dat_i = '0;
    step(); step();
    n_chk++; if (owner_o !== 2'b00) begin n_fail++; $display("FAIL reset_owner: got %b want 00", owner_o); end
    n_chk++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || s_sel_o !== 16'h0) begin
      n_fail++; $display("FAIL reset_sbus: cyc=%b stb=%b sel=%h want 0", s_cyc_o, s_stb_o, s_sel_o); end
    n_chk++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ackerr: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_round_robin();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_sel_i = 16'hffff; m0_adr_i = 32'h0000_1000;
    m0_dat_i = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_sel_i = 16'h00f0; m1_adr_i = 32'h0000_2000;
    #1;
    n_chk++; if (s_cyc_o !== 1'b0) begin n_fail++; $display("FAIL rr_latency: s_cyc_o=%b want 0", s_cyc_o); end
    step();
    n_chk++; if (owner_o !== 2'b01) begin n_fail++; $display("FAIL rr_first_m0: owner=%b want 01", owner_o); end
    n_chk++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h0000_1000 || s_we_o !== 1'b1) begin
      n_fail++; $display("FAIL rr_m0_bus: cyc=%b adr=%h we=%b want 1 00001000 1", s_cyc_o, s_adr_o, s_we_o); end
    n_chk++; if (s_dat_o !== 128'h0123_4567_89ab_cdef_0011_2233_4455_6677 || s_sel_o !== 16'hffff) begin
      n_fail++; $display("FAIL rr_m0_dat: dat=%h sel=%h", s_dat_o, s_sel_o); end
    s_ack_i = 1'b1; s_dat_i = 128'hdead_beef_0000_0000_cafe_f00d_1234_5678;
    #1;
    n_chk++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_m0_ack: m0=%b m1=%b want 1 0", m0_ack_o, m1_ack_o); end
    n_chk++; if (m_dat_o !== 128'hdead_beef_0000_0000_cafe_f00d_1234_5678) begin
      n_fail++; $display("FAIL rr_mdat: got %h", m_dat_o); end
    step();
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    n_chk++; if (owner_o !== 2'b00 || s_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_dead_cycle: owner=%b cyc=%b want 00 0", owner_o, s_cyc_o); end
    step();
    n_chk++; if (owner_o !== 2'b10 || s_adr_o !== 32'h0000_2000 || s_sel_o !== 16'h00f0) begin
      n_fail++; $display("FAIL rr_second_m1: owner=%b adr=%h sel=%h want 10 00002000 00f0", owner_o, s_adr_o, s_sel_o); end
    s_ack_i = 1'b1;
    #1;
    n_chk++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_m1_ack: m1=%b m0=%b want 1 0", m1_ack_o, m0_ack_o); end
    step();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();
  endtask

  task automatic test_burst();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_adr_i = 32'h0000_3000;
    step();
    n_chk++; if (owner_o !== 2'b10) begin n_fail++; $display("FAIL burst_grant: owner=%b want 10", owner_o); end
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_ack_i = 1'b1;
      #1;
      n_chk++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL burst_ack%0d: m1=%b m0=%b want 1 0", b, m1_ack_o, m0_ack_o); end
      step();
      s_ack_i = 1'b0; m1_stb_i = 1'b0;
      #1;
      n_chk++; if (owner_o !== 2'b10 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b0) begin
        n_fail++; $display("FAIL burst_gap%0d: owner=%b cyc=%b stb=%b want 10 1 0", b, owner_o, s_cyc_o, s_stb_o); end
      step();
      m1_stb_i = 1'b1; m1_adr_i = m1_adr_i + 32'h10;
    end
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'b000;
    step();
    n_chk++; if (owner_o !== 2'b00) begin n_fail++; $display("FAIL burst_release: owner=%b want 00", owner_o); end
    step();
    n_chk++; if (owner_o !== 2'b01) begin n_fail++; $display("FAIL burst_m0_after: owner=%b want 01", owner_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();
  endtask

  task automatic test_timeout();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
    step();
    for (int k = 1; k < 8; k++) begin
      n_chk++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_early%0d: m0_err=%b want 0", k, m0_err_o); end
      step();
    end
    n_chk++; if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_err: m0_err=%b m1_err=%b want 1 0", m0_err_o, m1_err_o); end
    step();
    n_chk++; if (s_cyc_o !== 1'b0 || m0_err_o !== 1'b0 || owner_o !== 2'b01) begin
      n_fail++; $display("FAIL tmo_abort: cyc=%b err=%b owner=%b want 0 0 01", s_cyc_o, m0_err_o, owner_o); end
    s_ack_i = 1'b1;
    #1;
    n_chk++; if (m0_ack_o !== 1'b0) begin n_fail++; $display("FAIL tmo_late_ack: m0_ack=%b want 0", m0_ack_o); end
    step(); step();
    s_ack_i = 1'b0;
    n_chk++; if (owner_o !== 2'b01 || s_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_hold: owner=%b cyc=%b want 01 0", owner_o, s_cyc_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step();
    n_chk++; if (owner_o !== 2'b00) begin n_fail++; $display("FAIL tmo_idle: owner=%b want 00", owner_o); end
    step();
  endtask

  task automatic test_ack_err();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    step();
    repeat (5) step();
    s_ack_i = 1'b1; s_err_i = 1'b1;
    #1;
    n_chk++; if (m0_err_o !== 1'b1 || m0_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
      n_fail++; $display("FAIL both_resp: err=%b ack=%b m1_err=%b want 1 0 0", m0_err_o, m0_ack_o, m1_err_o); end
    step();
    s_ack_i = 1'b0; s_err_i = 1'b0;
    repeat (6) step();
    n_chk++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL clr_cnt_early: m0_err=%b want 0", m0_err_o); end
    step();
    n_chk++; if (m0_err_o !== 1'b1) begin n_fail++; $display("FAIL clr_cnt_tmo: m0_err=%b want 1", m0_err_o); end
    step();
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    step();
    n_chk++; if (owner_o !== 2'b10 || s_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: owner=%b cyc=%b want 10 1", owner_o, s_cyc_o); end
    s_ack_i = 1'b1;
    rst_ni = 1'b0;
    #1;
    n_chk++; if (s_cyc_o !== 1'b0 || owner_o !== 2'b00) begin
      n_fail++; $display("FAIL rst_mid_drop: cyc=%b owner=%b want 0 00", s_cyc_o, owner_o); end
    n_chk++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_ackerr: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    step();
    s_ack_i = 1'b0;
    rst_ni = 1'b1;
    step();
    n_chk++; if (owner_o !== 2'b01) begin n_fail++; $display("FAIL rst_mid_regrant: owner=%b want 01", owner_o); end
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_timeout();
    test_ack_err();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
